// File: rtl/cicero_pkg.sv
// Shared CICERO types for the character-window front end.
// Holds the FSM encoding, the per-slot record and override-word packing.
package cicero_pkg;

    localparam int CHAR_W = 8;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        RUN,
        DRAIN
    } fsm_state_t;

    typedef struct packed {
        logic [CHAR_W-1:0] ch;
        logic              en;
        logic              eos;
    } slot_t;

    // {slot_id, pc} with the slot id above the pc field
    function automatic logic [31:0] ovr_word(
        input int unsigned slot,
        input int unsigned pc,
        input int unsigned pc_w
    );
        return (32'(slot) << pc_w) | 32'(pc);
    endfunction

endpackage

// File: rtl/window_slot_ring.sv
// Window slot storage: W slot registers, head/tail pointers
// and packing of the flat window outputs.
module window_slot_ring
    import cicero_pkg::*;
#(
    parameter int CHARACTER_WIDTH = CHAR_W,
    parameter int CC_ID_BITS      = 1,
    localparam int W              = 2 ** CC_ID_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         clr_i,
    input  logic                         wr_i,
    input  logic [CHARACTER_WIDTH-1:0]   wr_char_i,
    input  logic                         wr_last_i,
    input  logic                         pop_i,
    input  logic                         retire_i,
    output logic [CC_ID_BITS-1:0]        head_o,
    output logic [CC_ID_BITS-1:0]        tail_o,
    output logic [W-1:0]                 en_o,
    output logic [W-1:0]                 eos_o,
    output logic [W*CHARACTER_WIDTH-1:0] window_o
);

    slot_t                 slots_q [W];
    slot_t                 slots_d [W];
    logic [CC_ID_BITS-1:0] head_q, head_d;
    logic [CC_ID_BITS-1:0] tail_q, tail_d;

    always_comb begin
        slots_d = slots_q;
        head_d  = head_q;
        tail_d  = tail_q;
        if (clr_i) begin
            for (int i = 0; i < W; i++) begin
                slots_d[i] = '0;
            end
            head_d = '0;
            tail_d = '0;
        end else begin
            if (retire_i) begin
                slots_d[head_q].en  = 1'b0;
                slots_d[head_q].eos = 1'b0;
                head_d              = head_q + CC_ID_BITS'(1);
            end
            if (wr_i) begin
                slots_d[tail_q].ch  = CHAR_W'(wr_char_i);
                slots_d[tail_q].en  = 1'b1;
                slots_d[tail_q].eos = wr_last_i;
                tail_d              = tail_q + CC_ID_BITS'(1);
            end
            if (pop_i) begin
                head_d = head_q + CC_ID_BITS'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < W; i++) begin
                slots_q[i] <= '0;
            end
            head_q <= '0;
            tail_q <= '0;
        end else begin
            slots_q <= slots_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
        end
    end

    always_comb begin
        window_o = '0;
        en_o     = '0;
        eos_o    = '0;
        for (int i = 0; i < W; i++) begin
            window_o[i*CHARACTER_WIDTH +: CHARACTER_WIDTH] =
                CHARACTER_WIDTH'(slots_q[i].ch);
            en_o[i]  = slots_q[i].en;
            eos_o[i] = slots_q[i].eos;
        end
    end

    assign head_o = head_q;
    assign tail_o = tail_q;

endmodule

// File: rtl/window_feeder.sv
// CICERO character-window feeder: stream in, sliding window out.
// Start-thread injection is built only with WINDOW_FEEDER_INJECT_EN.
module window_feeder
    import cicero_pkg::*;
#(
    parameter int CHARACTER_WIDTH = 8,
    parameter int PC_WIDTH        = 8,
    parameter int CC_ID_BITS      = 1,
    parameter int START_PC        = 0,
    localparam int W              = 2 ** CC_ID_BITS,
    localparam int OW             = PC_WIDTH + CC_ID_BITS
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         start,
    input  logic [CHARACTER_WIDTH-1:0]   in_char,
    input  logic                         in_last,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [W-1:0]                 elaborating_chars,
    output logic [W*CHARACTER_WIDTH-1:0] cur_window,
    output logic [W-1:0]                 cur_window_enable,
    output logic [W-1:0]                 cur_window_end_of_s,
    output logic                         new_char,
    output logic [OW-1:0]                override_data,
    output logic                         override_valid,
    input  logic                         override_ready,
    output logic                         done
);

    fsm_state_t            state_q, state_d;
    logic                  new_char_q, new_char_d;
    logic                  done_q, done_d;
    logic [CC_ID_BITS-1:0] head, tail;
    logic [W-1:0]          en;
    logic                  clr, wr, pop, retire;
    logic                  acc, pend, slot_free;

    window_slot_ring #(
        .CHARACTER_WIDTH(CHARACTER_WIDTH),
        .CC_ID_BITS     (CC_ID_BITS)
    ) u_ring (
        .clk      (clk),
        .rst      (rst),
        .clr_i    (clr),
        .wr_i     (wr),
        .wr_char_i(in_char),
        .wr_last_i(in_last),
        .pop_i    (pop),
        .retire_i (retire),
        .head_o   (head),
        .tail_o   (tail),
        .en_o     (en),
        .eos_o    (cur_window_end_of_s),
        .window_o (cur_window)
    );

    assign cur_window_enable = en;
    assign slot_free         = !elaborating_chars[head];
    assign acc               = in_valid && in_ready;

    always_comb begin
        in_ready = 1'b0;
        unique case (state_q)
            FILL:    in_ready = !pend;
            RUN:     in_ready = slot_free && !pend;
            default: in_ready = 1'b0;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        clr        = 1'b0;
        wr         = 1'b0;
        pop        = 1'b0;
        retire     = 1'b0;
        new_char_d = 1'b0;
        done_d     = 1'b0;
        unique case (state_q)
            IDLE: begin
                clr = 1'b1;
                if (start) state_d = FILL;
            end
            FILL: begin
                if (acc) begin
                    wr = 1'b1;
                    if (in_last) state_d = DRAIN;
                    else if (tail == CC_ID_BITS'(W - 1)) state_d = RUN;
                end
            end
            RUN: begin
                if (acc) begin
                    wr         = 1'b1;
                    pop        = 1'b1;
                    new_char_d = 1'b1;
                    if (in_last) state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (slot_free && en[head]) begin
                    retire     = 1'b1;
                    new_char_d = 1'b1;
                end else if (en == '0 && !pend) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            new_char_q <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            new_char_q <= new_char_d;
            done_q     <= done_d;
        end
    end

    assign new_char = new_char_q;
    assign done     = done_q;

`ifdef WINDOW_FEEDER_INJECT_EN
    logic          pend_q, pend_d;
    logic [OW-1:0] ovr_q, ovr_d;

    // The loaded slot is always tail, also for RUN shifts (head == tail)
    always_comb begin
        pend_d = pend_q;
        ovr_d  = ovr_q;
        if (acc) begin
            pend_d = 1'b1;
            ovr_d  = OW'(ovr_word(32'(tail), 32'(START_PC),
                                  32'(PC_WIDTH)));
        end else if (override_ready) begin
            pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pend_q <= 1'b0;
            ovr_q  <= '0;
        end else begin
            pend_q <= pend_d;
            ovr_q  <= ovr_d;
        end
    end

    assign pend           = pend_q;
    assign override_valid = pend_q;
    assign override_data  = ovr_q;
`else
    logic unused_ovr_ready;

    assign unused_ovr_ready = override_ready;
    assign pend             = 1'b0;
    assign override_valid   = 1'b0;
    assign override_data    = '0;
`endif

endmodule

// File: tb/tb_window_feeder.sv
// Bench for window_feeder: a W=2 and a W=4 instance share one input stream.
// Accepted characters feed a scoreboard checked one cycle later.
`timescale 1ns/1ps
module tb_window_feeder;

    localparam int SPC = 3;
`ifdef WINDOW_FEEDER_INJECT_EN
    localparam bit INJ = 1'b1;
`else
    localparam bit INJ = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start2 = 1'b0, start4 = 1'b0;
    logic [7:0]  in_char = '0;
    logic        in_last = 1'b0, in_valid = 1'b0;
    logic        ovr_rdy = 1'b1;
    logic [1:0]  elab2 = '0;
    logic [3:0]  elab4 = '0;

    logic        rdy2, nc2, ov2, done2;
    logic [15:0] win2;
    logic [1:0]  en2, eos2;
    logic [8:0]  od2;
    logic        rdy4, nc4, ov4, done4;
    logic [31:0] win4;
    logic [3:0]  en4, eos4;
    logic [9:0]  od4;

    window_feeder #(.CC_ID_BITS(1), .START_PC(SPC)) u_dut2 (
        .clk(clk), .rst(rst), .start(start2),
        .in_char(in_char), .in_last(in_last), .in_valid(in_valid),
        .in_ready(rdy2), .elaborating_chars(elab2),
        .cur_window(win2), .cur_window_enable(en2),
        .cur_window_end_of_s(eos2), .new_char(nc2),
        .override_data(od2), .override_valid(ov2),
        .override_ready(ovr_rdy), .done(done2)
    );

    window_feeder #(.CC_ID_BITS(2), .START_PC(SPC)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4),
        .in_char(in_char), .in_last(in_last), .in_valid(in_valid),
        .in_ready(rdy4), .elaborating_chars(elab4),
        .cur_window(win4), .cur_window_enable(en4),
        .cur_window_end_of_s(eos4), .new_char(nc4),
        .override_data(od4), .override_valid(ov4),
        .override_ready(ovr_rdy), .done(done4)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, got, exp);
        end
    endtask

    typedef struct {
        bit         sel;
        int         slot;
        logic [7:0] ch;
        logic       last;
    } exp_t;

    exp_t sb[$];
    int   tl2 = 0, tl4 = 0;
    logic ov_seen = 1'b0;
`ifdef WINDOW_FEEDER_INJECT_EN
    int         inj2[$], inj4[$];
    logic       h2 = 1'b0, h4 = 1'b0;
    logic [9:0] hd2 = '0, hd4 = '0;
    logic [63:0] x;
`endif

    always @(negedge clk) begin
        exp_t e;
        if (rst) begin
            sb.delete();
            tl2 = 0;
            tl4 = 0;
`ifdef WINDOW_FEEDER_INJECT_EN
            inj2.delete();
            inj4.delete();
            h2 = 1'b0;
            h4 = 1'b0;
`endif
        end else begin
            ov_seen = ov_seen | ov2 | ov4;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                if (e.sel) begin
                    chk("win4", win4[e.slot*8 +: 8], e.ch);
                    chk("en4", en4[e.slot], 1);
                    chk("eos4", eos4[e.slot], e.last);
                end else begin
                    chk("win2", win2[e.slot*8 +: 8], e.ch);
                    chk("en2", en2[e.slot], 1);
                    chk("eos2", eos2[e.slot], e.last);
                end
            end
`ifdef WINDOW_FEEDER_INJECT_EN
            if (h2) chk("hold2", {ov2, od2}, {1'b1, hd2[8:0]});
            if (h4) chk("hold4", {ov4, od4}, {1'b1, hd4});
            h2  = ov2 && !ovr_rdy;
            hd2 = {1'b0, od2};
            h4  = ov4 && !ovr_rdy;
            hd4 = od4;
            if (ov2 && ovr_rdy) begin
                x = (inj2.size() > 0) ? 64'(inj2.pop_front()) : '1;
                chk("inj2", od2, x);
            end
            if (ov4 && ovr_rdy) begin
                x = (inj4.size() > 0) ? 64'(inj4.pop_front()) : '1;
                chk("inj4", od4, x);
            end
`endif
            if (start2) tl2 = 0;
            if (start4) tl4 = 0;
            if (in_valid && rdy2) begin
                sb.push_back('{1'b0, tl2, in_char, in_last});
`ifdef WINDOW_FEEDER_INJECT_EN
                inj2.push_back((tl2 << 8) | SPC);
`else
                chk("ovr_off2", {ov2, od2}, 0);
`endif
                tl2 = (tl2 + 1) % 2;
            end
            if (in_valid && rdy4) begin
                sb.push_back('{1'b1, tl4, in_char, in_last});
`ifdef WINDOW_FEEDER_INJECT_EN
                inj4.push_back((tl4 << 8) | SPC);
`else
                chk("ovr_off4", {ov4, od4}, 0);
`endif
                tl4 = (tl4 + 1) % 4;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) start4 = 1'b1;
        else start2 = 1'b1;
        tick();
        start2 = 1'b0;
        start4 = 1'b0;
    endtask

    task automatic send(input bit sel, input logic [7:0] c,
                        input bit last, output int acyc);
        int n;
        n        = 0;
        in_char  = c;
        in_last  = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!(sel ? rdy4 : rdy2) && n < 100) begin
            @(negedge clk);
            n++;
        end
        acyc = cyc;
        if (n >= 100) chk("send_timeout", n, 0);
        tick();
    endtask

    task automatic idle_in();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic drain_check(input bit sel, input int exp_nc);
        int nc, zc, dc, dn;
        logic [3:0] en;
        nc = 0;
        zc = -1;
        dc = -1;
        dn = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            en = sel ? en4 : {2'b00, en2};
            if (sel ? nc4 : nc2) nc++;
            if (en == '0 && zc < 0) zc = i;
            if (sel ? done4 : done2) begin
                dn++;
                if (dc < 0) dc = i;
            end
            if (dc >= 0 && i >= dc + 2) break;
        end
        chk("drain_nc", nc, exp_nc);
        chk("done_seen", dc >= 0, 1);
        chk("done_lat", dc - zc, 1);
        chk("done_width", dn, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int         t, a0, a3, bad;
        logic [8:0] d0;
        string      s;

        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_rdy", {rdy2, rdy4}, 0);
        chk("rst_win", {win2, win4}, 0);
        chk("rst_en", {en2, en4}, 0);
        chk("rst_eos", {eos2, eos4}, 0);
        chk("rst_nc", {nc2, nc4}, 0);
        chk("rst_done", {done2, done4}, 0);
        chk("rst_ov", {ov2, ov4}, 0);
        chk("rst_od", {od2, od4}, 0);

        // Valid characters while idle stay in the stream
        tick();
        in_char  = "z";
        in_valid = 1'b1;
        bad      = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rdy2 || rdy4 || en2 != 0 || en4 != 0) bad++;
        end
        chk("idle_ignore", bad, 0);
        tick();
        idle_in();

        // "ab", window held busy until inspected
        elab2 = 2'b11;
        pulse_start(1'b0);
        send(1'b0, "a", 1'b0, t);
        send(1'b0, "b", 1'b1, t);
        idle_in();
        @(negedge clk);
        chk("t1_en", en2, 2'b11);
        chk("t1_eos", eos2, 2'b10);
        chk("t1_win", win2, {8'h62, 8'h61});
        chk("t1_rdy", rdy2, 0);
        tick();
        elab2 = 2'b00;
        drain_check(1'b0, 2);

        // "abcd" with slot 0 busy after fill
        pulse_start(1'b0);
        send(1'b0, "a", 1'b0, t);
        send(1'b0, "b", 1'b0, t);
        elab2    = 2'b01;
        in_char  = "c";
        in_valid = 1'b1;
        bad      = 0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (rdy2 || nc2) bad++;
        end
        chk("t2_stall", bad, 0);
        tick();
        elab2 = 2'b00;
        send(1'b0, "c", 1'b0, t);
        idle_in();
        @(negedge clk);
        chk("t2_nc_on", nc2, 1);
        @(negedge clk);
        chk("t2_nc_off", nc2, 0);
        tick();
        send(1'b0, "d", 1'b1, t);
        idle_in();
        drain_check(1'b0, 3);

`ifdef WINDOW_FEEDER_INJECT_EN
        // Injection held while override_ready is low
        ovr_rdy = 1'b0;
        pulse_start(1'b0);
        send(1'b0, "p", 1'b0, t);
        in_char  = "q";
        in_valid = 1'b1;
        bad      = 0;
        d0       = '0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i == 0) d0 = od2;
            if (rdy2 || !ov2 || od2 != d0) bad++;
        end
        chk("t3_data", d0, SPC);
        chk("t3_stall", bad, 0);
        tick();
        ovr_rdy = 1'b1;
        send(1'b0, "q", 1'b1, t);
        idle_in();
        drain_check(1'b0, 2);
`endif

        // W=4, nine characters: slots wrap twice
        s = "abcdefghi";
        pulse_start(1'b1);
        for (int i = 0; i < 9; i++) begin
            send(1'b1, s[i], i == 8, t);
        end
        idle_in();
        drain_check(1'b1, 5);

        // Reset in the middle of RUN
        pulse_start(1'b0);
        send(1'b0, "k", 1'b0, t);
        send(1'b0, "l", 1'b0, t);
        send(1'b0, "m", 1'b0, t);
        idle_in();
        @(negedge clk);
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mr_win", win2, 0);
        chk("mr_en", en2, 0);
        chk("mr_eos", eos2, 0);
        chk("mr_nc", nc2, 0);
        chk("mr_ov", {ov2, od2}, 0);
        chk("mr_rdy", {rdy2, done2}, 0);
        tick();
        pulse_start(1'b0);
        send(1'b0, "x", 1'b0, t);
        send(1'b0, "y", 1'b1, t);
        idle_in();
        drain_check(1'b0, 2);

        // Four characters with valid held high during FILL
        pulse_start(1'b1);
        send(1'b1, "w", 1'b0, a0);
        send(1'b1, "x", 1'b0, t);
        send(1'b1, "y", 1'b0, t);
        send(1'b1, "z", 1'b1, a3);
        idle_in();
        chk("fill_rate", a3 - a0, INJ ? 6 : 3);
        drain_check(1'b1, 4);

        repeat (3) @(negedge clk);
        chk("ov_seen", ov_seen, INJ);
        chk("sb_left", sb.size(), 0);
`ifdef WINDOW_FEEDER_INJECT_EN
        chk("inj_left", inj2.size() + inj4.size(), 0);
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/window_feeder.md
# window_feeder

Character-window front end of a CICERO core: accepts the input string as a byte stream and keeps a sliding window of 2**CC_ID_BITS characters. It drives the cur_window / cur_window_enable / cur_window_end_of_s / new_char inputs of the engine topology and injects one start thread per loaded character on the topology's override channel. It retires the oldest window slot only once no engine is still elaborating that slot.

## Interface
- CHARACTER_WIDTH, 8, bits per character
- PC_WIDTH, 8, program-counter width
- CC_ID_BITS, 1, log2 of window slots (W = 2**CC_ID_BITS)
- START_PC, 0, PC injected for every newly loaded character

- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- start  in  1  one-cycle pulse; begins a string (ignored unless IDLE)
- in_char  in  CHARACTER_WIDTH  stream character
- in_last  in  1  marks the last character (the terminator) of the string
- in_valid  in  1  stream valid
- in_ready  out  1  stream ready
- elaborating_chars  in  W  per-slot busy flags from the topology
- cur_window  out  W*CHARACTER_WIDTH  slot i at bits [i*CHARACTER_WIDTH +: CHARACTER_WIDTH]
- cur_window_enable  out  W  slot holds a valid character
- cur_window_end_of_s  out  W  slot holds the terminator
- new_char  out  1  one-cycle pulse on every window shift
- override_data  out  PC_WIDTH+CC_ID_BITS  {slot_id, START_PC}, slot_id in the MSBs
- override_valid  out  1  injection valid
- override_ready  in  1  injection accepted
- done  out  1  one-cycle pulse when the string is fully retired

## Operation
- State machine with states IDLE, FILL, RUN, DRAIN.
- head: CC_ID_BITS-bit index of the oldest slot; wraps mod W naturally.
- tail: index of the next slot to load; wraps mod W naturally.
- IDLE
  - All slot registers are cleared.
  - start moves the FSM to FILL with head = tail = 0.
- FILL
  - Accept a character into slot tail; set enable, and set end_of_s = in_last.
  - tail++.
  - After W characters are loaded, go to RUN.
  - in_last accepted during FILL goes directly to DRAIN.
- RUN
  - Shift condition: elaborating_chars[head]==0, no pending injection, and in_valid.
  - On shift: accept the character into slot head (head==tail), head++, tail++, pulse new_char.
  - in_last accepted goes to DRAIN.
- DRAIN
  - The stream is closed and in_ready=0.
  - When elaborating_chars[head]==0 and enable[head]==1: clear enable and end_of_s of slot head, head++, pulse new_char.
  - When all enables are 0: pulse done and go to IDLE.
- Injection
  - Every accepted character creates one pending injection {slot_id, START_PC}.
  - override_valid holds with stable data until override_ready is sampled high.
  - While an injection is pending, in_ready=0, so at most one injection is outstanding.
- in_ready = (FILL or RUN-shift-condition-without-in_valid) and no pending injection. in_ready depends combinationally on elaborating_chars and override state only, never on in_valid.
- Characters in_valid while in IDLE are not consumed.

## Timing
- Reset values: state IDLE; all slot registers 0; all outputs 0; head = tail = 0; no pending injection.
- Reset asserted mid-string drops the window and any pending injection the next cycle, without emitting done.
- Accept-to-window latency: 1 cycle. A character accepted in cycle t appears on cur_window / enable in t+1, together with new_char in t+1 for RUN shifts. override_valid also rises in t+1.
- Back-to-back acceptance: a character every 2 cycles minimum when override_ready is held high (accept, then inject).
- A shift and the busy flag rising on the same slot in the same cycle: the shift wins; the topology must not raise busy for a slot whose enable is being cleared.
- done is asserted exactly 1 cycle after the last enable clears.

## Configuration
- WINDOW_FEEDER_INJECT_EN defined: injection behaves as described above.
- Without the macro:
  - override_valid is tied 0 and override_data is tied 0.
  - No pending-injection state exists.
  - in_ready ignores injection, so one character per cycle is possible.
  - Start threads are then supplied by an external source.

## Structure
- Shared cicero package holds:
  - the fsm_state_t enum (IDLE/FILL/RUN/DRAIN);
  - the slot_t struct {char, enable, end_of_s};
  - the override-word packing helper.
- One natural sub-module: window_slot_ring (W slot registers, head/tail pointers and packing of the flat outputs); the FSM and injection logic stay in window_feeder.

## Test plan
- CC_ID_BITS=1, stream "ab" with in_last on b, override_ready=1.
  - Response: two injections, {0,START_PC} then {1,START_PC}.
  - Window enable=2'b11, end_of_s=2'b10.
  - After elaborating_chars=0: two new_char pulses, then done.
- Stream "abcd" (W=2), elaborating_chars[0] held high 10 cycles after FILL.
  - Response: no shift and in_ready=0 for 10 cycles.
  - Then 'c' loads slot 0, head=1, new_char for one cycle.
- override_ready low 5 cycles during FILL.
  - Response: override_valid and data stable for 5 cycles; in_ready=0 throughout; no character lost.
- W=4 with 9 characters.
  - Response: head wraps 3→0 twice, and the slot order of injections is 0,1,2,3,0,1,2,3,0.
- rst pulsed mid-RUN.
  - Response: the next cycle all outputs are 0 and state is IDLE; a fresh start yields a correct FILL.
- Build without WINDOW_FEEDER_INJECT_EN, stream of 4 characters with in_valid held high.
  - Response: override_valid is never 1; FILL accepts one character per cycle.
